// File: rtl/qkt_result_collector_pkg.sv
// Shared types, default parameters and width helpers for the QK^T result collector.
package qkt_result_collector_pkg;

  // Lifecycle of one ping-pong bank.
  typedef enum logic [1:0] {
    BankEmpty   = 2'd0,
    BankFilling = 2'd1,
    BankFull    = 2'd2
  } bank_state_e;

  localparam int unsigned DefWidthOut     = 16;
  localparam int unsigned DefChunkSize    = 4;
  localparam int unsigned DefNumCoresA    = 2;
  localparam int unsigned DefNumCoresB    = 2;
  localparam int unsigned DefTotalModules = 1;
  localparam int unsigned DefTotalInputW  = 2;
  localparam int unsigned DefNumBlocks    = 3;

  // One matmul result slice: every element of every core chunk of every module.
  function automatic int unsigned calc_slice_w(input int unsigned width_out,
                                               input int unsigned chunk_size,
                                               input int unsigned num_cores_a,
                                               input int unsigned num_cores_b,
                                               input int unsigned total_modules);
    return width_out * chunk_size * num_cores_a * num_cores_b * total_modules;
  endfunction

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qkt_result_bank.sv
// One collector bank: full-row writes, single-slice combinational reads.
module qkt_result_bank #(
  parameter int unsigned SliceW      = 256,
  parameter int unsigned NumBlocks   = 3,
  parameter int unsigned TotalInputW = 2,
  parameter int unsigned BlkW        = 2,
  parameter int unsigned WW          = 1
) (
  input  logic                          clk_i,
  input  logic                          wr_en_i,
  input  logic [BlkW-1:0]               wr_row_i,
  input  logic [SliceW*TotalInputW-1:0] wr_data_i,
  input  logic [BlkW-1:0]               rd_row_i,
  input  logic [WW-1:0]                 rd_w_i,
  output logic [SliceW-1:0]             rd_data_o
);

  localparam int unsigned RowW = SliceW * TotalInputW;

  logic [RowW-1:0] mem_q [NumBlocks];
  logic [RowW-1:0] rd_row;

  // Row storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_row_i] <= wr_data_i;
    end
  end

  assign rd_row = mem_q[rd_row_i];

  // Select the addressed slice out of the current row.
  always_comb begin
    rd_data_o = '0;
    for (int unsigned w = 0; w < TotalInputW; w++) begin
      if (rd_w_i == WW'(w)) begin
        rd_data_o = rd_row[w*SliceW +: SliceW];
      end
    end
  end

endmodule

// File: rtl/qkt_result_collector.sv
// Ping-pong collector: gathers NUM_BLOCKS matmul strobes per bank, then
// streams the bank out slice by slice in block-major order.
module qkt_result_collector
  import qkt_result_collector_pkg::*;
#(
  parameter int unsigned WIDTH_OUT     = DefWidthOut,
  parameter int unsigned CHUNK_SIZE    = DefChunkSize,
  parameter int unsigned NUM_CORES_A   = DefNumCoresA,
  parameter int unsigned NUM_CORES_B   = DefNumCoresB,
  parameter int unsigned TOTAL_MODULES = DefTotalModules,
  parameter int unsigned TOTAL_INPUT_W = DefTotalInputW,
  parameter int unsigned NUM_BLOCKS    = DefNumBlocks,
  localparam int unsigned SLICE_W      = calc_slice_w(WIDTH_OUT, CHUNK_SIZE, NUM_CORES_A,
                                                      NUM_CORES_B, TOTAL_MODULES),
  localparam int unsigned BLK_W        = idx_w(NUM_BLOCKS),
  localparam int unsigned W_W          = idx_w(TOTAL_INPUT_W)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [SLICE_W*TOTAL_INPUT_W-1:0] in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SLICE_W-1:0]               out_data,
  output logic [BLK_W-1:0]                 out_blk,
  output logic [W_W-1:0]                   out_w,
  output logic                             out_last,
  output logic                             frame_done,
  output logic                             overflow
);

  localparam logic [BLK_W-1:0] LastBlk = BLK_W'(NUM_BLOCKS - 1);
  localparam logic [W_W-1:0]   LastW   = W_W'(TOTAL_INPUT_W - 1);

  bank_state_e        state_q [2];
  bank_state_e        state_d [2];
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [BLK_W-1:0]   wr_blk_q, wr_blk_d;
  logic [BLK_W-1:0]   rd_blk_q, rd_blk_d;
  logic [W_W-1:0]     rd_w_q, rd_w_d;
  logic               frame_done_q, frame_done_d;
  logic               overflow_q, overflow_d;

  logic               wr_fire;
  logic               rd_fire;
  logic [1:0]         bank_wr_en;
  logic [SLICE_W-1:0] bank_rd_data [2];

  assign in_ready   = (state_q[wr_bank_q] != BankFull);
  assign out_valid  = (state_q[rd_bank_q] == BankFull);
  assign out_last   = (rd_blk_q == LastBlk) && (rd_w_q == LastW);
  assign out_blk    = rd_blk_q;
  assign out_w      = rd_w_q;
  assign out_data   = bank_rd_data[rd_bank_q];
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

  // A strobe against a full write bank is dropped here and only flagged.
  assign wr_fire = in_valid & in_ready;
  assign rd_fire = out_valid & out_ready;

  // Route the write strobe to the bank currently being filled.
  always_comb begin
    bank_wr_en = '0;
    bank_wr_en[wr_bank_q] = wr_fire;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    qkt_result_bank #(
      .SliceW      (SLICE_W),
      .NumBlocks   (NUM_BLOCKS),
      .TotalInputW (TOTAL_INPUT_W),
      .BlkW        (BLK_W),
      .WW          (W_W)
    ) u_bank (
      .clk_i     (clk),
      .wr_en_i   (bank_wr_en[b]),
      .wr_row_i  (wr_blk_q),
      .wr_data_i (in_data),
      .rd_row_i  (rd_blk_q),
      .rd_w_i    (rd_w_q),
      .rd_data_o (bank_rd_data[b])
    );
  end

  // Next-state for bank lifecycle, write pointer and read pointer.
  // Write and final read never target the same bank: writes need !FULL,
  // reads need FULL.
  always_comb begin
    state_d[0]   = state_q[0];
    state_d[1]   = state_q[1];
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_blk_d     = wr_blk_q;
    rd_blk_d     = rd_blk_q;
    rd_w_d       = rd_w_q;
    frame_done_d = rd_fire & out_last;
    overflow_d   = overflow_q | (in_valid & ~in_ready);

    if (wr_fire) begin
      if (wr_blk_q == LastBlk) begin
        state_d[wr_bank_q] = BankFull;
        wr_blk_d           = '0;
        wr_bank_d          = ~wr_bank_q;
      end else begin
        state_d[wr_bank_q] = BankFilling;
        wr_blk_d           = wr_blk_q + BLK_W'(1);
      end
    end

    if (rd_fire) begin
      if (rd_w_q == LastW) begin
        rd_w_d = '0;
        if (rd_blk_q == LastBlk) begin
          rd_blk_d           = '0;
          state_d[rd_bank_q] = BankEmpty;
          rd_bank_d          = ~rd_bank_q;
        end else begin
          rd_blk_d = rd_blk_q + BLK_W'(1);
        end
      end else begin
        rd_w_d = rd_w_q + W_W'(1);
      end
    end
  end

  // Control state registers; reset discards both banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q[0]   <= BankEmpty;
      state_q[1]   <= BankEmpty;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_blk_q     <= '0;
      rd_blk_q     <= '0;
      rd_w_q       <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q[0]   <= state_d[0];
      state_q[1]   <= state_d[1];
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_blk_q     <= wr_blk_d;
      rd_blk_q     <= rd_blk_d;
      rd_w_q       <= rd_w_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_qkt_result_collector.sv
// Bench for qkt_result_collector: frame-level reference model plus scenario tasks.
module tb_qkt_result_collector;

  localparam int unsigned SW   = 256;
  localparam int unsigned TW   = 2;
  localparam int unsigned NB   = 3;
  localparam int unsigned IN_W = SW * TW;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [IN_W-1:0] in_data;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_data;
  logic [1:0]      out_blk;
  logic            out_w;
  logic            out_last;
  logic            frame_done;
  logic            overflow;

  qkt_result_collector dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_blk    (out_blk),
    .out_w      (out_w),
    .out_last   (out_last),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] data;
    logic [1:0]    blk;
    logic          w;
    logic          last;
  } word_t;

  // Model: the collector is a two-deep buffer of complete frames.
  word_t exp_q[$];
  word_t part_q[$];
  int    fill_cnt;
  int    full_frames;
  logic  ovf_exp;
  logic  fd_exp;
  bit    mon_en;

  int n_checks;
  int n_pass;

  logic          obs_ready, obs_valid, obs_last, obs_fd, obs_ovf, obs_w;
  logic [SW-1:0] obs_data;
  logic [1:0]    obs_blk;
  logic          xfer;

  function automatic logic [IN_W-1:0] mk_row(input logic [7:0] a, input logic [7:0] b);
    logic [IN_W-1:0] r;
    r = '0;
    r[7:0] = a;
    r[SW +: 8] = b;
    return r;
  endfunction

  function automatic logic [IN_W-1:0] rand_row();
    logic [IN_W-1:0] r;
    for (int i = 0; i < int'(IN_W / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [SW-1:0] slice_of(input logic [IN_W-1:0] r, input int w);
    return r[w*SW +: SW];
  endfunction

  task automatic model_clear();
    exp_q.delete();
    part_q.delete();
    fill_cnt    = 0;
    full_frames = 0;
    ovf_exp     = 1'b0;
    fd_exp      = 1'b0;
  endtask

  // One clock: sample at negedge, drive, then advance the model at posedge.
  task automatic cycle(input logic v, input logic [IN_W-1:0] d, input logic rdy);
    word_t wd;
    bit    acc;
    bit    pop;
    @(negedge clk);
    obs_ready = in_ready;
    obs_valid = out_valid;
    obs_data  = out_data;
    obs_blk   = out_blk;
    obs_w     = out_w;
    obs_last  = out_last;
    obs_fd    = frame_done;
    obs_ovf   = overflow;
    xfer      = out_valid & rdy;
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    @(posedge clk);
    acc = v && (full_frames < 2);
    pop = (full_frames > 0) && rdy;
    if (v && full_frames >= 2) ovf_exp = 1'b1;
    fd_exp = 1'b0;
    if (pop) begin
      wd = exp_q.pop_front();
      if (wd.last) begin
        full_frames--;
        fd_exp = 1'b1;
      end
    end
    if (acc) begin
      for (int w = 0; w < int'(TW); w++) begin
        wd.data = slice_of(d, w);
        wd.blk  = 2'(fill_cnt);
        wd.w    = 1'(w);
        wd.last = (fill_cnt == int'(NB) - 1) && (w == int'(TW) - 1);
        part_q.push_back(wd);
      end
      fill_cnt++;
      if (fill_cnt == int'(NB)) begin
        foreach (part_q[i]) exp_q.push_back(part_q[i]);
        part_q.delete();
        fill_cnt = 0;
        full_frames++;
      end
    end
  endtask

  // Continuous comparison of every observable output against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (in_ready !== (full_frames < 2))
        $display("FAIL mon_in_ready t=%0t got %b want %b", $time, in_ready, full_frames < 2);
      else n_pass++;
      n_checks++;
      if (out_valid !== (full_frames > 0))
        $display("FAIL mon_out_valid t=%0t got %b want %b", $time, out_valid, full_frames > 0);
      else n_pass++;
      n_checks++;
      if (overflow !== ovf_exp)
        $display("FAIL mon_overflow t=%0t got %b want %b", $time, overflow, ovf_exp);
      else n_pass++;
      n_checks++;
      if (frame_done !== fd_exp)
        $display("FAIL mon_frame_done t=%0t got %b want %b", $time, frame_done, fd_exp);
      else n_pass++;
      if (full_frames > 0 && exp_q.size() > 0) begin
        n_checks++;
        if (out_data !== exp_q[0].data || out_blk !== exp_q[0].blk ||
            out_w !== exp_q[0].w || out_last !== exp_q[0].last)
          $display("FAIL mon_word t=%0t got %h/%0d/%0d/%b want %h/%0d/%0d/%b", $time,
                   out_data, out_blk, out_w, out_last, exp_q[0].data, exp_q[0].blk,
                   exp_q[0].w, exp_q[0].last);
        else n_pass++;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        frame_done !== 1'b0 || overflow !== 1'b0)
      $display("FAIL %s got rdy=%b vld=%b last=%b fd=%b ovf=%b want 1/0/0/0/0", tag,
               in_ready, out_valid, out_last, frame_done, overflow);
    else n_pass++;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    model_clear();
    @(negedge clk);
    check_reset_outputs("reset_hold");
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_initial");
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [SW-1:0] want [6];
    logic [SW-1:0] got  [$];
    int            fd_cnt;
    int            last_idx;
    want = '{SW'(8'hA0), SW'(8'hA1), SW'(8'hB0), SW'(8'hB1), SW'(8'hC0), SW'(8'hC1)};
    cycle(1'b1, mk_row(8'hA0, 8'hA1), 1'b1);
    cycle(1'b1, mk_row(8'hB0, 8'hB1), 1'b1);
    cycle(1'b1, mk_row(8'hC0, 8'hC1), 1'b1);
    n_checks++;
    if (obs_valid !== 1'b0) $display("FAIL single_early_valid got %b want 0", obs_valid);
    else n_pass++;
    fd_cnt   = 0;
    last_idx = -1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (i == 0) begin
        n_checks++;
        if (obs_valid !== 1'b1) $display("FAIL single_latency got %b want 1", obs_valid);
        else n_pass++;
      end
      if (xfer) begin
        if (obs_last) last_idx = got.size();
        got.push_back(obs_data);
      end
      if (obs_fd) fd_cnt++;
    end
    n_checks++;
    if (got.size() != 6) $display("FAIL single_count got %0d want 6", got.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== want[i]) $display("FAIL single_word%0d got %h want %h", i, got[i], want[i]);
      else n_pass++;
    end
    n_checks++;
    if (last_idx != 5) $display("FAIL single_last_pos got %0d want 5", last_idx);
    else n_pass++;
    n_checks++;
    if (fd_cnt != 1) $display("FAIL single_frame_done got %0d want 1", fd_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int drops;
    int nx;
    drops = 0;
    nx    = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, rand_row(), 1'b1);
      if (obs_ready !== 1'b1) drops++;
      if (xfer) nx++;
    end
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (xfer) nx++;
    end
    n_checks++;
    if (drops != 0) $display("FAIL pingpong_in_ready got %0d drops want 0", drops);
    else n_pass++;
    n_checks++;
    if (nx != 12) $display("FAIL pingpong_count got %0d want 12", nx);
    else n_pass++;
    n_checks++;
    if (obs_ovf !== 1'b0) $display("FAIL pingpong_overflow got %b want 0", obs_ovf);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int nx;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, rand_row(), 1'b0);
      n_checks++;
      if (obs_ready !== (i < 6))
        $display("FAIL bp_in_ready%0d got %b want %b", i, obs_ready, i < 6);
      else n_pass++;
    end
    nx = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (i == 0) begin
        n_checks++;
        if (obs_ovf !== 1'b1) $display("FAIL bp_overflow got %b want 1", obs_ovf);
        else n_pass++;
      end
      if (xfer) nx++;
    end
    n_checks++;
    if (nx != 12) $display("FAIL bp_count got %0d want 12", nx);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic          pat [4];
    logic [SW-1:0] pd;
    logic [1:0]    pb;
    logic          pw;
    bit            stalled;
    int            nx;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_row(), 1'b1);
    stalled = 0;
    nx      = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, '0, pat[i % 4]);
      if (stalled && obs_valid) begin
        n_checks++;
        if (obs_data !== pd || obs_blk !== pb || obs_w !== pw)
          $display("FAIL stall_hold%0d got %h/%0d/%0d want %h/%0d/%0d", i, obs_data, obs_blk,
                   obs_w, pd, pb, pw);
        else n_pass++;
      end
      stalled = obs_valid && !pat[i % 4];
      pd = obs_data;
      pb = obs_blk;
      pw = obs_w;
      if (xfer) nx++;
    end
    n_checks++;
    if (nx != 6) $display("FAIL stall_count got %0d want 6", nx);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [IN_W-1:0] rows [3];
    logic [SW-1:0]   got [$];
    for (int i = 0; i < 2; i++) cycle(1'b1, rand_row(), 1'b0);
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      rows[i] = rand_row();
      cycle(1'b1, rows[i], 1'b1);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (xfer) got.push_back(obs_data);
    end
    n_checks++;
    if (got.size() != 6) $display("FAIL rstmid_count got %0d want 6", got.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== slice_of(rows[i / 2], i % 2))
        $display("FAIL rstmid_word%0d got %h want %h", i, got[i], slice_of(rows[i / 2], i % 2));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), rand_row(), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 30; i++) cycle(1'b0, '0, 1'b1);
    n_checks++;
    if (obs_valid !== 1'b0) $display("FAIL random_drain got out_valid %b want 0", obs_valid);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    mon_en   = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    pulse_reset();
    test_stall();
    test_reset_mid_frame();
    test_random();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
